// File: rtl/dcache_line_mover_pkg.sv
// Shared definitions for the D-cache line mover: geometry constants and FSM encoding.
package dcache_line_mover_pkg;

  localparam int LINE_W   = 128;
  localparam int WORD_W   = 32;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 2;
  localparam int TAG_LSB  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } mover_state_t;

  function automatic int tag_width(input int pabits);
    return pabits - TAG_LSB;
  endfunction

endpackage

// File: rtl/dcache_wrap_counter.sv
// 2-bit word counter that starts at a loaded base and flags the last word before wrapping back to it.
module dcache_wrap_counter
  import dcache_line_mover_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [OFFSET_W-1:0] load_value,
  input  logic                inc,
  output logic [OFFSET_W-1:0] count,
  output logic                at_base,
  output logic                wrap
);

  logic [OFFSET_W-1:0] base_q;
  logic [OFFSET_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      base_q  <= load_value;
      count_q <= load_value;
    end else if (inc) begin
      count_q <= count_q + 2'd1;
    end
  end

  assign count   = count_q;
  assign at_base = (count_q == base_q);
  // Last word of the sweep: one more increment lands back on the base.
  assign wrap    = ((count_q + 2'd1) == base_q);

endmodule

// File: rtl/dcache_line_mover.sv
// Memory-side engine for one D-cache line: optional dirty-line writeback, then critical-word-first fill.
// Memory handshake: a request (Mem_Read or Mem_Write) with its address/data is held until Mem_Ready is seen high in the same cycle.
module dcache_line_mover
  import dcache_line_mover_pkg::*;
#(
  parameter int PABITS = 36
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      Start,
  input  logic                      DoWriteback,
  input  logic                      DoFill,
  input  logic [INDEX_W-1:0]        Index,
  input  logic [OFFSET_W-1:0]       Offset,
  input  logic [PABITS-TAG_LSB-1:0] FillTag,
  input  logic [PABITS-TAG_LSB-1:0] WbTag,
  input  logic [LINE_W-1:0]         WbLine,
  output logic                      Busy,
  output logic                      Done,
  output logic [INDEX_W-1:0]        LineIndex,
  output logic [OFFSET_W-1:0]       LineOffset,
  output logic [WORD_W-1:0]         LineIn,
  output logic                      FillLine,
  output logic                      CriticalWord,
  output logic [PABITS-3:0]         Mem_Address,
  output logic                      Mem_Read,
  output logic                      Mem_Write,
  output logic [WORD_W-1:0]         Mem_DataOut,
  input  logic [WORD_W-1:0]         Mem_DataIn,
  input  logic                      Mem_Ready
);

  mover_state_t state, next_state;

  logic [INDEX_W-1:0]        idx_q;
  logic [OFFSET_W-1:0]       off_q;
  logic [PABITS-TAG_LSB-1:0] fill_tag_q;
  logic [PABITS-TAG_LSB-1:0] wb_tag_q;
  logic [LINE_W-1:0]         line_q;
  logic                      do_fill_q;

  logic [INDEX_W-1:0]        line_index_q;
  logic [OFFSET_W-1:0]       line_offset_q;
  logic [WORD_W-1:0]         line_in_q;
  logic                      fill_line_q;
  logic                      crit_q;

  logic                      cnt_load;
  logic [OFFSET_W-1:0]       cnt_base;
  logic                      cnt_inc;
  logic [OFFSET_W-1:0]       cnt;
  logic                      cnt_at_base;
  logic                      cnt_wrap;
  logic                      fill_accept;

  dcache_wrap_counter u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_base),
    .inc        (cnt_inc),
    .count      (cnt),
    .at_base    (cnt_at_base),
    .wrap       (cnt_wrap)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      off_q      <= '0;
      fill_tag_q <= '0;
      wb_tag_q   <= '0;
      line_q     <= '0;
      do_fill_q  <= 1'b0;
    end else if (state == IDLE && Start) begin
      idx_q      <= Index;
      off_q      <= Offset;
      fill_tag_q <= FillTag;
      wb_tag_q   <= WbTag;
      line_q     <= WbLine;
      do_fill_q  <= DoFill;
    end
  end

  // Fill words reach the cache set one cycle after memory accepts them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_index_q  <= '0;
      line_offset_q <= '0;
      line_in_q     <= '0;
      fill_line_q   <= 1'b0;
      crit_q        <= 1'b0;
    end else begin
      fill_line_q <= fill_accept;
      crit_q      <= fill_accept && cnt_at_base;
      if (fill_accept) begin
        line_index_q  <= idx_q;
        line_offset_q <= cnt;
        line_in_q     <= Mem_DataIn;
      end
    end
  end

  assign fill_accept = (state == FILL) && Mem_Ready;

  always_comb begin
    next_state  = state;
    cnt_load    = 1'b0;
    cnt_base    = off_q;
    cnt_inc     = 1'b0;
    Mem_Read    = 1'b0;
    Mem_Write   = 1'b0;
    Mem_Address = '0;
    Mem_DataOut = '0;
    Done        = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          cnt_load = 1'b1;
          cnt_base = DoWriteback ? 2'd0 : Offset;
          if (DoWriteback) next_state = WB;
          else if (DoFill) next_state = FILL;
          else             next_state = DONE;
        end
      end
      WB: begin
        Mem_Write   = 1'b1;
        Mem_Address = {wb_tag_q, idx_q, cnt};
        Mem_DataOut = line_q[{cnt, 5'b0} +: WORD_W];
        if (Mem_Ready) begin
          cnt_inc = 1'b1;
          if (cnt_wrap) begin
            if (do_fill_q) begin
              next_state = FILL;
              cnt_load   = 1'b1;
              cnt_base   = off_q;
            end else begin
              next_state = DONE;
            end
          end
        end
      end
      FILL: begin
        Mem_Read    = 1'b1;
        Mem_Address = {fill_tag_q, idx_q, cnt};
        if (Mem_Ready) begin
          cnt_inc = 1'b1;
          if (cnt_wrap) next_state = DONE;
        end
      end
      DONE: begin
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign Busy         = (state == WB) || (state == FILL);
  assign LineIndex    = line_index_q;
  assign LineOffset   = line_offset_q;
  assign LineIn       = line_in_q;
  assign FillLine     = fill_line_q;
  assign CriticalWord = crit_q;

endmodule

// File: tb/tb_dcache_line_mover.sv
// Directed self-checking bench for dcache_line_mover: writeback/fill ordering, stalls, ignored inputs, reset.
module tb_dcache_line_mover;

  localparam int PABITS = 36;
  localparam int TAG_W  = PABITS - 10;
  localparam int MA_W   = PABITS - 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              Start = 1'b0;
  logic              DoWriteback = 1'b0;
  logic              DoFill = 1'b0;
  logic [5:0]        Index = '0;
  logic [1:0]        Offset = '0;
  logic [TAG_W-1:0]  FillTag = '0;
  logic [TAG_W-1:0]  WbTag = '0;
  logic [127:0]      WbLine = '0;
  logic              Busy, Done, FillLine, CriticalWord, Mem_Read, Mem_Write;
  logic [5:0]        LineIndex;
  logic [1:0]        LineOffset;
  logic [31:0]       LineIn, Mem_DataOut;
  logic [MA_W-1:0]   Mem_Address;
  logic [31:0]       Mem_DataIn = '0;
  logic              Mem_Ready = 1'b0;

  dcache_line_mover #(.PABITS(PABITS)) dut (
    .clock(clock), .reset(reset), .Start(Start), .DoWriteback(DoWriteback), .DoFill(DoFill),
    .Index(Index), .Offset(Offset), .FillTag(FillTag), .WbTag(WbTag), .WbLine(WbLine),
    .Busy(Busy), .Done(Done), .LineIndex(LineIndex), .LineOffset(LineOffset), .LineIn(LineIn),
    .FillLine(FillLine), .CriticalWord(CriticalWord), .Mem_Address(Mem_Address),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_DataOut(Mem_DataOut),
    .Mem_DataIn(Mem_DataIn), .Mem_Ready(Mem_Ready)
  );

  always #5 clock = ~clock;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [MA_W-1:0] wr_addr[$];
  logic [31:0]     wr_data[$];
  logic [MA_W-1:0] rd_addr[$];
  logic [1:0]      fl_off[$];
  logic [5:0]      fl_idx[$];
  logic [31:0]     fl_data[$];
  logic            fl_crit[$];
  int              done_cycle, both_high, unstable, busy_bad;
  logic            fill_at_done;

  function automatic logic [31:0] mem_word(input logic [MA_W-1:0] a);
    return {4'hD, a[27:0]};
  endfunction

  // Runs one transaction from a Start pulse, playing the memory side and recording what the DUT does.
  task automatic run_txn(input bit wb, input bit fill, input logic [5:0] idx, input logic [1:0] off,
                         input logic [TAG_W-1:0] ftag, input logic [TAG_W-1:0] wtag,
                         input logic [127:0] line, input int stall, input bit poke, input int budget);
    int cyc, stall_left;
    bit prev_req, prev_acc;
    logic [MA_W-1:0] prev_addr;
    logic [31:0] prev_data;
    logic [1:0] prev_rw;
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
    fl_off.delete(); fl_idx.delete(); fl_data.delete(); fl_crit.delete();
    done_cycle = -1; both_high = 0; unstable = 0; busy_bad = 0; fill_at_done = 1'b0;
    @(negedge clock);
    Start = 1'b1; DoWriteback = wb; DoFill = fill; Index = idx; Offset = off;
    FillTag = ftag; WbTag = wtag; WbLine = line;
    @(negedge clock);
    Start = 1'b0; WbLine = ~line; WbTag = ~wtag; FillTag = ~ftag; Index = ~idx; Offset = ~off;
    cyc = 1; stall_left = stall;
    prev_req = 1'b0; prev_acc = 1'b0; prev_addr = '0; prev_data = '0; prev_rw = '0;
    while (cyc <= budget) begin
      if (Mem_Read && Mem_Write) both_high++;
      if (FillLine) begin
        fl_off.push_back(LineOffset); fl_idx.push_back(LineIndex);
        fl_data.push_back(LineIn); fl_crit.push_back(CriticalWord);
      end
      if (Done) begin
        done_cycle = cyc; fill_at_done = FillLine;
        if (Busy) busy_bad++;
        break;
      end
      if (Busy !== (wb || fill)) busy_bad++;
      Start = (poke && cyc == 2);
      if (Mem_Read || Mem_Write) begin
        if (prev_req && !prev_acc &&
            (Mem_Address !== prev_addr || Mem_DataOut !== prev_data || {Mem_Read, Mem_Write} !== prev_rw))
          unstable++;
        if (stall_left > 0) begin
          Mem_Ready = 1'b0; stall_left--;
        end else begin
          Mem_Ready = 1'b1; stall_left = stall;
          if (Mem_Write) begin wr_addr.push_back(Mem_Address); wr_data.push_back(Mem_DataOut); end
          else rd_addr.push_back(Mem_Address);
        end
        Mem_DataIn = Mem_Ready ? mem_word(Mem_Address) : 32'hBAD0_BAD0;
      end else begin
        Mem_Ready = 1'b0;
      end
      prev_req = Mem_Read || Mem_Write; prev_acc = Mem_Ready;
      prev_addr = Mem_Address; prev_data = Mem_DataOut; prev_rw = {Mem_Read, Mem_Write};
      @(negedge clock);
      cyc++;
    end
    Start = 1'b0; Mem_Ready = 1'b0; DoWriteback = 1'b0; DoFill = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({Busy, Done, LineIndex, LineOffset, LineIn, FillLine, CriticalWord, Mem_Address,
         Mem_Read, Mem_Write, Mem_DataOut} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b addr=%h rd=%b wr=%b linein=%h",
               Busy, Done, Mem_Address, Mem_Read, Mem_Write, LineIn);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_fill_only();
    logic [1:0] exp_off[4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [TAG_W-1:0] ftag = 26'h123;
    logic [MA_W-1:0] ea;
    run_txn(1'b0, 1'b1, 6'd5, 2'd2, ftag, 26'h0, 128'h0, 0, 1'b0, 40);
    total_cnt++;
    if (done_cycle !== 5) $display("FAIL fill_only_latency: got %0d expected 5", done_cycle);
    else pass_cnt++;
    total_cnt++;
    if (rd_addr.size() !== 4 || fl_off.size() !== 4 || wr_addr.size() !== 0)
      $display("FAIL fill_only_counts: reads %0d pulses %0d writes %0d expected 4 4 0",
               rd_addr.size(), fl_off.size(), wr_addr.size());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      ea = {ftag, 6'd5, exp_off[k]};
      total_cnt++;
      if (k >= rd_addr.size() || rd_addr[k] !== ea)
        $display("FAIL fill_only_addr[%0d]: got %h expected %h", k, k < rd_addr.size() ? rd_addr[k] : 'x, ea);
      else pass_cnt++;
      total_cnt++;
      if (k >= fl_off.size() || fl_off[k] !== exp_off[k] || fl_idx[k] !== 6'd5 ||
          fl_data[k] !== mem_word(ea) || fl_crit[k] !== (k == 0))
        $display("FAIL fill_only_pulse[%0d]: got off=%0d idx=%0d data=%h crit=%b expected off=%0d idx=5 data=%h crit=%b",
                 k, k < fl_off.size() ? fl_off[k] : 'x, k < fl_idx.size() ? fl_idx[k] : 'x,
                 k < fl_data.size() ? fl_data[k] : 'x, k < fl_crit.size() ? fl_crit[k] : 1'bx,
                 exp_off[k], mem_word(ea), k == 0);
      else pass_cnt++;
    end
    total_cnt++;
    if (fill_at_done !== 1'b1 || busy_bad !== 0)
      $display("FAIL fill_only_done_busy: fill_at_done=%b busy_errors=%0d expected 1 0", fill_at_done, busy_bad);
    else pass_cnt++;
  endtask

  task automatic test_wb_fill();
    logic [127:0] ln = {32'hD, 32'hC, 32'hB, 32'hA};
    logic [31:0] exp_wd[4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    logic [TAG_W-1:0] ftag = 26'h2A;
    logic [TAG_W-1:0] wtag = 26'h7;
    run_txn(1'b1, 1'b1, 6'd9, 2'd0, ftag, wtag, ln, 0, 1'b0, 40);
    total_cnt++;
    if (done_cycle !== 9) $display("FAIL wb_fill_latency: got %0d expected 9", done_cycle);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (k >= wr_addr.size() || wr_addr[k] !== {wtag, 6'd9, 2'(k)} || wr_data[k] !== exp_wd[k])
        $display("FAIL wb_fill_write[%0d]: got addr=%h data=%h expected addr=%h data=%h", k,
                 k < wr_addr.size() ? wr_addr[k] : 'x, k < wr_data.size() ? wr_data[k] : 'x,
                 {wtag, 6'd9, 2'(k)}, exp_wd[k]);
      else pass_cnt++;
      total_cnt++;
      if (k >= rd_addr.size() || rd_addr[k] !== {ftag, 6'd9, 2'(k)})
        $display("FAIL wb_fill_read[%0d]: got %h expected %h", k,
                 k < rd_addr.size() ? rd_addr[k] : 'x, {ftag, 6'd9, 2'(k)});
      else pass_cnt++;
    end
    total_cnt++;
    if (both_high !== 0 || fl_off.size() !== 4 || fill_at_done !== 1'b1)
      $display("FAIL wb_fill_exclusive: both_high=%0d pulses=%0d fill_at_done=%b expected 0 4 1",
               both_high, fl_off.size(), fill_at_done);
    else pass_cnt++;
  endtask

  task automatic test_stalls();
    logic [1:0] exp_off[4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [127:0] ln = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    run_txn(1'b1, 1'b1, 6'h3F, 2'd3, 26'h3FFFFFF, 26'h15, ln, 3, 1'b0, 80);
    total_cnt++;
    if (done_cycle !== 33) $display("FAIL stall_latency: got %0d expected 33", done_cycle);
    else pass_cnt++;
    total_cnt++;
    if (unstable !== 0 || both_high !== 0)
      $display("FAIL stall_hold: unstable=%0d both_high=%0d expected 0 0", unstable, both_high);
    else pass_cnt++;
    total_cnt++;
    if (fl_off.size() !== 4 || wr_addr.size() !== 4)
      $display("FAIL stall_pulse_count: pulses=%0d writes=%0d expected 4 4", fl_off.size(), wr_addr.size());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (k >= fl_off.size() || fl_off[k] !== exp_off[k] || fl_idx[k] !== 6'h3F ||
          k >= wr_data.size() || wr_data[k] !== ln[32*k +: 32])
        $display("FAIL stall_word[%0d]: got off=%0d wdata=%h expected off=%0d wdata=%h", k,
                 k < fl_off.size() ? fl_off[k] : 'x, k < wr_data.size() ? wr_data[k] : 'x,
                 exp_off[k], ln[32*k +: 32]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignored_inputs();
    int bad = 0;
    logic [127:0] ln = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    @(negedge clock);
    Mem_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (Mem_Read || Mem_Write || Busy || Done || FillLine) bad++;
    end
    Mem_Ready = 1'b0;
    total_cnt++;
    if (bad !== 0) $display("FAIL idle_ready_ignored: got %0d active cycles expected 0", bad);
    else pass_cnt++;
    run_txn(1'b1, 1'b1, 6'd12, 2'd1, 26'h44, 26'h33, ln, 0, 1'b1, 40);
    total_cnt++;
    if (done_cycle !== 9 || fl_off.size() !== 4 || busy_bad !== 0)
      $display("FAIL busy_start_ignored: done=%0d pulses=%0d busy_errors=%0d expected 9 4 0",
               done_cycle, fl_off.size(), busy_bad);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (k >= wr_data.size() || wr_data[k] !== ln[32*k +: 32] || wr_addr[k] !== {26'h33, 6'd12, 2'(k)})
        $display("FAIL victim_captured[%0d]: got %h expected %h", k,
                 k < wr_data.size() ? wr_data[k] : 'x, ln[32*k +: 32]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_fill();
    int dones = 0;
    @(negedge clock);
    Start = 1'b1; DoWriteback = 1'b0; DoFill = 1'b1; Index = 6'd2; Offset = 2'd1; FillTag = 26'h55;
    @(negedge clock);
    Start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      Mem_Ready = 1'b1; Mem_DataIn = mem_word(Mem_Address);
      @(negedge clock);
    end
    Mem_Ready = 1'b0;
    total_cnt++;
    if (Mem_Read !== 1'b1 || FillLine !== 1'b1 || LineOffset !== 2'd2)
      $display("FAIL mid_fill_progress: rd=%b fill=%b off=%0d expected 1 1 2", Mem_Read, FillLine, LineOffset);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({Busy, Done, LineIndex, LineOffset, LineIn, FillLine, CriticalWord, Mem_Address,
         Mem_Read, Mem_Write, Mem_DataOut} !== '0)
      $display("FAIL reset_mid_fill_outputs: busy=%b rd=%b addr=%h linein=%h fill=%b expected all 0",
               Busy, Mem_Read, Mem_Address, LineIn, FillLine);
    else pass_cnt++;
    Mem_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (Done || Busy || Mem_Read) dones++;
    end
    Mem_Ready = 1'b0;
    reset = 1'b1;
    total_cnt++;
    if (dones !== 0) $display("FAIL reset_no_done: got %0d active cycles expected 0", dones);
    else pass_cnt++;
    run_txn(1'b0, 1'b1, 6'd2, 2'd1, 26'h55, 26'h0, 128'h0, 0, 1'b0, 40);
    total_cnt++;
    if (done_cycle !== 5 || fl_off.size() !== 4 || fl_crit.size() < 1 || fl_crit[0] !== 1'b1)
      $display("FAIL post_reset_txn: done=%0d pulses=%0d expected 5 4 with critical first",
               done_cycle, fl_off.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 1'b0, 6'd1, 2'd0, 26'h1, 26'h2, 128'h5, 0, 1'b0, 10);
    total_cnt++;
    if (done_cycle !== 1 || rd_addr.size() !== 0 || wr_addr.size() !== 0 || fl_off.size() !== 0 || busy_bad !== 0)
      $display("FAIL neither_txn: done=%0d reads=%0d writes=%0d pulses=%0d busy_errors=%0d expected 1 0 0 0 0",
               done_cycle, rd_addr.size(), wr_addr.size(), fl_off.size(), busy_bad);
    else pass_cnt++;
    run_txn(1'b1, 1'b0, 6'd7, 2'd3, 26'h9, 26'hABC, 128'h77, 0, 1'b0, 20);
    total_cnt++;
    if (done_cycle !== 5 || wr_addr.size() !== 4 || rd_addr.size() !== 0 || fill_at_done !== 1'b0)
      $display("FAIL wb_only_back_to_back: done=%0d writes=%0d reads=%0d fill_at_done=%b expected 5 4 0 0",
               done_cycle, wr_addr.size(), rd_addr.size(), fill_at_done);
    else pass_cnt++;
    run_txn(1'b0, 1'b1, 6'd8, 2'd3, 26'hF0, 26'h0, 128'h0, 0, 1'b0, 20);
    total_cnt++;
    if (done_cycle !== 5 || fl_off.size() !== 4 || rd_addr.size() < 1 || rd_addr[0] !== {26'hF0, 6'd8, 2'd3})
      $display("FAIL fill_back_to_back: done=%0d pulses=%0d expected 5 4 starting at offset 3",
               done_cycle, fl_off.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_only();
    test_wb_fill();
    test_stalls();
    test_ignored_inputs();
    test_reset_mid_fill();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_line_mover.md
Name: dcache_line_mover

Overview:
Memory-side engine for one data-cache line transaction: optional writeback of a dirty 128-bit line, then optional critical-word-first line fill. It serialises the captured victim line into four 32-bit memory writes. It then issues four memory reads, starting at the requested word and wrapping, and returns each word to the cache set as a LineIn/LineOffset/LineIndex/FillLine pulse. It sits between the D-cache controller and the word-wide memory bus.

Parameters:
PABITS, 36, physical address width; tag width is PABITS-10, memory word address width is PABITS-2.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
Start  in  1  one-cycle request pulse; accepted only in IDLE.
DoWriteback  in  1  sampled with Start: run the writeback phase.
DoFill  in  1  sampled with Start: run the fill phase.
Index  in  6  line index, sampled with Start.
Offset  in  2  critical word offset, sampled with Start.
FillTag  in  PABITS-10  tag of the line to fetch, sampled with Start.
WbTag  in  PABITS-10  tag of the victim line, sampled with Start.
WbLine  in  128  victim line, word 0 in [31:0], sampled with Start.
Busy  out  1  high from the cycle after Start accept until Done.
Done  out  1  one-cycle completion pulse.
LineIndex  out  6  fill index to the cache set.
LineOffset  out  2  fill word offset to the cache set.
LineIn  out  32  fill data to the cache set.
FillLine  out  1  one-cycle pulse: write LineIn at LineIndex/LineOffset.
CriticalWord  out  1  pulse coincident with the first FillLine of a fill.
Mem_Address  out  PABITS-2  word address.
Mem_Read  out  1  read request, held until accepted.
Mem_Write  out  1  write request, held until accepted.
Mem_DataOut  out  32  write data.
Mem_DataIn  in  32  read data, valid when Mem_Ready is high during a read.
Mem_Ready  in  1  accepts the current word in the same cycle.

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE and all outputs to 0, including LineIn, Mem_Address and Mem_DataOut. Reset mid-transaction abandons it; no Done is issued.
- Start in IDLE captures Index, Offset, both tags, WbLine and both flags. The next state is WB if DoWriteback=1, else FILL if DoFill=1, else DONE.
- Start outside IDLE is ignored. Mem_Ready outside WB/FILL is ignored.
- Mem_Read and Mem_Write are never high together.
- WB state:
  - Mem_Write=1, Mem_Address={WbTag,Index,wcnt}, Mem_DataOut=line word wcnt, with wcnt running 0..3.
  - Mem_Ready advances wcnt.
  - Acceptance of word 3 moves to FILL if DoFill, else DONE.
- FILL state:
  - Mem_Read=1, Mem_Address={FillTag,Index,Offset+fcnt mod 4}, with fcnt running 0..3. Example: Offset=2 gives 2,3,0,1.
  - On each Mem_Ready, LineIn, LineOffset and LineIndex are registered and FillLine pulses in the following cycle.
  - CriticalWord accompanies the fcnt=0 pulse.
  - Acceptance of fcnt=3 moves to DONE.
- DONE: Done=1 for one cycle, coincident with the last FillLine when a fill ran. The next state is IDLE; Busy drops in the same cycle that Done is high.
- Mem_Ready held high gives one word per cycle. Stalls of any length hold the address, data and request steady.
- A new Start is accepted in the cycle after Done, since the block is back in IDLE.
- Minimum latency from Start to Done: WB+FILL = 9 cycles, fill only = 5, writeback only = 5, neither = 1.

Decomposition:
- Shared cache package: tag width expression (PABITS-10), line/word width constants, and the state encodings IDLE, WB, FILL, DONE.
- One sub-module is natural: dcache_wrap_counter, a 2-bit counter with load base, increment and a wrap flag. It is used for both wcnt and the fill offset.

Test Plan:
1. Fill only: Start with DoFill=1, Index=5, Offset=2, FillTag=0x123, Mem_Ready tied 1 -> Mem_Address word offsets 2,3,0,1. FillLine pulses with LineOffset 2,3,0,1 and LineIndex=5. CriticalWord on the first pulse only; Done after 5 cycles.
2. Writeback then fill: WbLine={0xD,0xC,0xB,0xA} (word 0 = 0xA), WbTag=0x7, Offset=0 -> writes 0xA,0xB,0xC,0xD to offsets 0..3 at tag 0x7, then reads offsets 0..3 at FillTag. Mem_Read and Mem_Write are never both high.
3. Stalls: Mem_Ready low for 3 cycles before each word -> address and data held stable throughout. Exactly 4 FillLine pulses; no duplicates.
4. Start while Busy and Mem_Ready while IDLE -> no state change and no memory request. The victim line is unaffected when WbLine changes after Start.
5. Reset asserted mid-FILL after 2 words -> all outputs 0 immediately, no Done. A new Start after reset release runs a complete transaction.
6. Start with DoWriteback=0 and DoFill=0 -> no memory activity and a Done pulse 1 cycle after Start.
